// File: rtl/inc16.sv
// ----------------------------------------------------------------------------
// inc16 - registered 16-bit incrementer, s = X + 1 (mod 2^WIDTH).
//
// The sum comes from a half-adder ripple chain with one half-adder per bit.
// It is registered on the rising edge of clk. cout flags the wrap from
// all-ones to zero.
//
// Ports
//   clk   in   1       rising-edge clock
//   rst   in   1       synchronous active-high reset; has priority over increment
//   X     in   WIDTH   operand, sampled every rising edge
//   s     out  WIDTH   registered X + 1, truncated to WIDTH
//   cout  out  1       registered carry-out of bit WIDTH-1
// ----------------------------------------------------------------------------
module inc16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    // Half-adder chain. Each bit keeps its own carry nets, which keeps the
    // ripple from looking like a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_lsb
            // The increment injects a constant carry-in at the LSB.
            assign c_in = 1'b1;
        end else begin : g_mid
            assign c_in = g_bit[i-1].c_out;
        end

        assign s_d[i] = X[i] ^ c_in;
        assign c_out  = X[i] & c_in;
    end

    assign cout_d = g_bit[WIDTH-1].c_out;

    // Result register; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_inc16.sv
// ----------------------------------------------------------------------------
// tb_inc16 - self-checking bench for inc16.
//
// The expected values come from plain wide arithmetic: (X + 1) mod 2^16,
// with the carry taken as bit 16. The bench runs directed boundary steps
// first. It then runs a randomized stream, a mid-stream reset and an
// exhaustive sweep of X.
// ----------------------------------------------------------------------------
module tb_inc16;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] s;
    logic             cout;

    int checks = 0;
    int errors = 0;

    inc16 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .X    (X),
        .s    (s),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 17-bit sum of the operand and one.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x);
        int unsigned full;
        full  = 32'(x) + 32'd1;
        model = (WIDTH+1)'(full);
    endfunction

    task automatic chk(input string tag, input logic [WIDTH:0] obs,
                       input logic [WIDTH:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed cout/s=%0h_%04h expected cout/s=%0h_%04h",
                   tag, obs[WIDTH], obs[WIDTH-1:0], exp[WIDTH], exp[WIDTH-1:0]);
        end
    endtask

    // Apply an operand, clock it in, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [WIDTH-1:0] x);
        rst = r;
        X   = x;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [WIDTH-1:0] x);
        step(1'b0, x);
        chk(tag, {cout, s}, model(x));
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        logic [WIDTH-1:0] seq [4];
        seq[0] = 16'd0;
        seq[1] = 16'd1945;
        seq[2] = 16'd255;
        seq[3] = 16'd65535;

        rst = 1'b1;
        X   = 16'h1234;
        #2;

        // Reset held for two edges.
        step(1'b1, 16'h1234);
        chk("reset_edge1", {cout, s}, 17'h0_0000);
        step(1'b1, 16'h1234);
        chk("reset_edge2", {cout, s}, 17'h0_0000);

        // Directed values and boundaries, with constants written out.
        step(1'b0, 16'h0000); chk("x_0000", {cout, s}, 17'h0_0001);
        step(1'b0, 16'h0799); chk("x_0799", {cout, s}, 17'h0_079A);
        step(1'b0, 16'h00FF); chk("x_00ff", {cout, s}, 17'h0_0100);
        step(1'b0, 16'h7FFF); chk("x_7fff", {cout, s}, 17'h0_8000);
        step(1'b0, 16'hFFFF); chk("x_ffff_wrap", {cout, s}, 17'h1_0000);
        step(1'b0, 16'h0005); chk("x_0005_after_wrap", {cout, s}, 17'h0_0006);

        // Back-to-back stream, one operand per cycle.
        foreach (seq[i]) step_chk("stream", seq[i]);

        // Outputs must hold while X changes between edges.
        step(1'b0, 16'h1000);
        X = 16'hABCD;
        #3;
        chk("hold_between_edges", {cout, s}, 17'h0_1001);
        @(posedge clk);
        #1;
        chk("after_midcycle_change", {cout, s}, 17'h0_ABCE);

        // Reset mid-stream discards the in-flight wrap result.
        step(1'b0, 16'hFFFF); chk("pre_reset_wrap", {cout, s}, 17'h1_0000);
        step(1'b1, 16'hFFFF); chk("mid_reset", {cout, s}, 17'h0_0000);
        step(1'b0, 16'h0010); chk("post_reset", {cout, s}, 17'h0_0011);

        // Randomized stream against the model.
        for (int n = 0; n < 500; n++) begin
            rv = WIDTH'($urandom);
            step_chk("random", rv);
        end

        // Exhaustive sweep of every operand value.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            step_chk("sweep", WIDTH'(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
